// File: rtl/hpdcache_mem_read_arbiter_if.sv
// Shared types and handshake bundle for the HPDcache memory read arbiter.
// Latency: none (wires only).
// Backpressure: carried by the valid/ready pairs inside the bundle.
//
// Ports (signals of the bundle):
//   req_valid_i/req_ready_o/req_i        per-requester read requests
//   mem_req_valid_o/mem_req_ready_i/mem_req_o     shared request to memory
//   mem_resp_valid_i/mem_resp_ready_o/mem_resp_i  shared response from memory
//   resp_valid_o/resp_ready_i/resp_o     per-requester responses
// Modport master is the arbiter's view; slave is the view of the
// requesters plus the memory side.
package hpdcache_mem_read_arbiter_pkg;
    localparam int unsigned MEM_ID_W = 4;

    typedef struct packed {
        logic [31:0]         mem_req_addr;
        logic [7:0]          mem_req_len;
        logic [2:0]          mem_req_size;
        logic [MEM_ID_W-1:0] mem_req_id;
    } hpdcache_mem_req_t;

    typedef struct packed {
        logic [1:0]          mem_resp_r_error;
        logic [MEM_ID_W-1:0] mem_resp_r_id;
        logic [31:0]         mem_resp_r_data;
        logic                mem_resp_r_last;
    } hpdcache_mem_resp_r_t;
endpackage

interface hpdcache_mem_read_arbiter_if
    import hpdcache_mem_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]                        req_valid_i;
    logic [N_REQ-1:0]                        req_ready_o;
    hpdcache_mem_req_t [N_REQ-1:0]           req_i;
    logic                                    mem_req_valid_o;
    logic                                    mem_req_ready_i;
    hpdcache_mem_req_t                       mem_req_o;
    logic                                    mem_resp_valid_i;
    logic                                    mem_resp_ready_o;
    hpdcache_mem_resp_r_t                    mem_resp_i;
    logic [N_REQ-1:0]                        resp_valid_o;
    logic [N_REQ-1:0]                        resp_ready_i;
    hpdcache_mem_resp_r_t [N_REQ-1:0]        resp_o;

    modport master (
        input  req_valid_i, req_i, mem_req_ready_i,
               mem_resp_valid_i, mem_resp_i, resp_ready_i,
        output req_ready_o, mem_req_valid_o, mem_req_o,
               mem_resp_ready_o, resp_valid_o, resp_o
    );

    modport slave (
        output req_valid_i, req_i, mem_req_ready_i,
               mem_resp_valid_i, mem_resp_i, resp_ready_i,
        input  req_ready_o, mem_req_valid_o, mem_req_o,
               mem_resp_ready_o, resp_valid_o, resp_o
    );
endinterface

// File: rtl/hpdcache_mem_read_arbiter.sv
// Round-robin arbiter of N_REQ read requesters onto one memory read port, with id-based response routing.
// Latency: zero-cycle request grant and response routing (combinational paths); only rr/lock/counter state is registered.
// Backpressure: grant is locked while mem_req_ready_i is low; response ready follows the addressed requester's resp_ready_i.
//
// Ports: clk_i (rising edge), rst_i (synchronous, active high),
//        bus (hpdcache_mem_read_arbiter_if.master) carrying all handshakes.
// Optional: define HPDCACHE_MEM_READ_ARB_OUTSTD_LIMIT_EN to cap in-flight
//           reads per requester at MAX_OUTSTD.
module hpdcache_mem_read_arbiter
    import hpdcache_mem_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MAX_OUTSTD = 4
)(
    input  logic                        clk_i,
    input  logic                        rst_i,
    hpdcache_mem_read_arbiter_if.master bus
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     lock_idx_q;
    logic                 lock_q;
    logic [IDX_W-1:0]     search_idx;
    logic                 found;
    logic [IDX_W-1:0]     winner;
    logic [N_REQ-1:0]     blocked;
    logic [N_REQ-1:0]     eligible;
    logic                 mem_req_valid;
    logic                 req_hs;
    logic [N_REQ-1:0]     req_ready;
    hpdcache_mem_req_t    mem_req_d;

    logic [IDX_W-1:0]     resp_idx;
    logic                 resp_in_range;
    logic [N_REQ-1:0]     resp_valid;
    logic                 mem_resp_ready;
    hpdcache_mem_resp_r_t resp_clean;

    assign eligible = bus.req_valid_i & ~blocked;

    // First eligible requester at or after rr_ptr, wrapping around.
    always_comb begin
        int unsigned cand;
        cand       = 0;
        search_idx = rr_ptr_q;
        found      = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(rr_ptr_q) + off) % N_REQ;
            if (!found && eligible[cand[IDX_W-1:0]]) begin
                search_idx = cand[IDX_W-1:0];
                found      = 1'b1;
            end
        end
    end

    // A stalled request keeps its winner even if it later becomes blocked.
    assign winner        = lock_q ? lock_idx_q : search_idx;
    assign mem_req_valid = !rst_i && (lock_q || found);
    assign req_hs        = mem_req_valid && bus.mem_req_ready_i;

    always_comb begin
        req_ready = '0;
        if (req_hs) begin
            req_ready[winner] = 1'b1;
        end
        mem_req_d = bus.req_i[winner];
        mem_req_d.mem_req_id[MEM_ID_W-1 -: IDX_W] = winner;
    end

    assign bus.mem_req_valid_o = mem_req_valid;
    assign bus.mem_req_o       = mem_req_d;
    assign bus.req_ready_o     = req_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (req_hs) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end else if (mem_req_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
        end
    end

    // Response side: the requester index rides in the top id bits.
    assign resp_idx      = bus.mem_resp_i.mem_resp_r_id[MEM_ID_W-1 -: IDX_W];
    assign resp_in_range = ({1'b0, resp_idx} < (IDX_W + 1)'(N_REQ));

    always_comb begin
        resp_valid     = '0;
        mem_resp_ready = 1'b0;
        resp_clean     = bus.mem_resp_i;
        resp_clean.mem_resp_r_id[MEM_ID_W-1 -: IDX_W] = '0;
        if (!rst_i) begin
            if (resp_in_range) begin
                resp_valid[resp_idx] = bus.mem_resp_valid_i;
                mem_resp_ready       = bus.resp_ready_i[resp_idx];
            end else begin
                // Ids that map to no requester are swallowed.
                mem_resp_ready = 1'b1;
            end
        end
    end

    assign bus.resp_valid_o     = resp_valid;
    assign bus.mem_resp_ready_o = mem_resp_ready;
    assign bus.resp_o           = {N_REQ{resp_clean}};

`ifdef HPDCACHE_MEM_READ_ARB_OUTSTD_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTD + 1);

    logic [N_REQ-1:0][CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0]            cnt_inc;
    logic [N_REQ-1:0]            cnt_dec;
    logic                        resp_last_hs;

    assign resp_last_hs = bus.mem_resp_valid_i && mem_resp_ready &&
                          bus.mem_resp_i.mem_resp_r_last && resp_in_range;

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        blocked = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_inc[i] = req_hs && (winner == IDX_W'(i));
            cnt_dec[i] = resp_last_hs && (resp_idx == IDX_W'(i));
            blocked[i] = (cnt_q[i] == CNT_W'(MAX_OUTSTD));
        end
    end

    // Simultaneous issue and completion cancel out; a stray completion at zero is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (!cnt_inc[i] && cnt_dec[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end
`else
    assign blocked = '0;
`endif

endmodule

// File: tb/tb_hpdcache_mem_read_arbiter.sv
module tb_hpdcache_mem_read_arbiter;
    import hpdcache_mem_read_arbiter_pkg::*;

`ifdef HPDCACHE_MEM_READ_ARB_OUTSTD_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    hpdcache_mem_read_arbiter_if #(.N_REQ(4)) bus ();

    hpdcache_mem_read_arbiter #(.N_REQ(4), .MAX_OUTSTD(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000 + 32'(i * 16);
    endfunction

    // Requester i sends id low bits (i+1)%4; the arbiter stamps i on top.
    function automatic logic [3:0] id_of(input int i);
        return 4'(i * 4 + (i + 1) % 4);
    endfunction

    task automatic idle_inputs();
        bus.req_valid_i      = '0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.resp_ready_i     = '0;
        bus.mem_resp_i       = '0;
    endtask

    task automatic set_resp(input logic [3:0] id, input logic [31:0] data);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_i       = '{mem_resp_r_error: 2'b00, mem_resp_r_id: id,
                                 mem_resp_r_data: data, mem_resp_r_last: 1'b1};
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_grant(input string tag, input int g, input logic [3:0] rdy);
        chk({tag, "_vld"}, 64'(bus.mem_req_valid_o), 64'd1);
        chk({tag, "_id"}, 64'(bus.mem_req_o.mem_req_id), 64'(id_of(g)));
        chk({tag, "_addr"}, 64'(bus.mem_req_o.mem_req_addr), 64'(addr_of(g)));
        chk({tag, "_rdy"}, 64'(bus.req_ready_o), 64'(rdy));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            bus.req_i[i] = '{mem_req_addr: addr_of(i), mem_req_len: 8'd0,
                             mem_req_size: 3'd3, mem_req_id: 4'((i + 1) % 4)};
        end
        idle_inputs();

        // Outputs held low while reset is asserted, even with live inputs.
        rst = 1'b1;
        bus.req_valid_i      = 4'b1111;
        bus.mem_req_ready_i  = 1'b1;
        bus.resp_ready_i     = 4'b1111;
        set_resp(4'b0100, 32'h1);
        #1;
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst_mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'd0);
        tick();
        do_reset();

        // Round robin with everybody asking and memory always ready.
        bus.req_valid_i     = 4'b1111;
        bus.mem_req_ready_i = 1'b1;
        #1;
        chk_grant("rr0", 0, 4'b0001); tick(); #1;
        chk_grant("rr1", 1, 4'b0010); tick(); #1;
        chk_grant("rr2", 2, 4'b0100); tick(); #1;
        chk_grant("rr3", 3, 4'b1000); tick(); #1;
        chk_grant("rr4", 0, 4'b0001);
        do_reset();

        // Stall on requester 2 while requester 3 joins: grant stays on 2.
        bus.req_valid_i = 4'b0100;
        #1;
        chk_grant("lock_c1", 2, 4'b0000); tick();
        bus.req_valid_i = 4'b1100;
        #1;
        chk_grant("lock_c2", 2, 4'b0000); tick(); #1;
        chk_grant("lock_c3", 2, 4'b0000); tick();
        bus.mem_req_ready_i = 1'b1;
        #1;
        chk_grant("lock_hs", 2, 4'b0100); tick();
        bus.req_valid_i = 4'b1000;
        #1;
        chk_grant("lock_next", 3, 4'b1000);
        do_reset();

        // Response routed to requester 1, waiting on its ready.
        set_resp(4'b0111, 32'hCAFE_0001);
        #1;
        chk("rsp_c1_valid", 64'(bus.resp_valid_o), 64'b0010);
        chk("rsp_c1_ready", 64'(bus.mem_resp_ready_o), 64'd0);
        chk("rsp_c1_id", 64'(bus.resp_o[1].mem_resp_r_id), 64'b0011);
        chk("rsp_c1_data", 64'(bus.resp_o[1].mem_resp_r_data), 64'hCAFE_0001);
        tick(); #1;
        chk("rsp_c2_valid", 64'(bus.resp_valid_o), 64'b0010);
        chk("rsp_c2_ready", 64'(bus.mem_resp_ready_o), 64'd0);
        tick();
        bus.resp_ready_i = 4'b1101;
        #1;
        chk("rsp_other_ready", 64'(bus.mem_resp_ready_o), 64'd0);
        tick();
        bus.resp_ready_i = 4'b0010;
        #1;
        chk("rsp_c3_valid", 64'(bus.resp_valid_o), 64'b0010);
        chk("rsp_c3_ready", 64'(bus.mem_resp_ready_o), 64'd1);
        chk("rsp_c3_id", 64'(bus.resp_o[1].mem_resp_r_id), 64'b0011);
        do_reset();

        // Outstanding cap of 2 for requester 0, freed by one last beat.
        bus.req_valid_i     = 4'b0001;
        bus.mem_req_ready_i = 1'b1;
        #1;
        chk("cap_c1_rdy", 64'(bus.req_ready_o), 64'b0001); tick(); #1;
        chk("cap_c2_rdy", 64'(bus.req_ready_o), 64'b0001); tick(); #1;
        chk("cap_c3_vld", 64'(bus.mem_req_valid_o), 64'(!LIM));
        chk("cap_c3_rdy", 64'(bus.req_ready_o), LIM ? 64'b0000 : 64'b0001);
        tick();
        set_resp(4'b0001, 32'h5);
        bus.resp_ready_i = 4'b0001;
        #1;
        chk("cap_c4_vld", 64'(bus.mem_req_valid_o), 64'(!LIM));
        chk("cap_c4_resp_rdy", 64'(bus.mem_resp_ready_o), 64'd1);
        tick();
        bus.mem_resp_valid_i = 1'b0;
        #1;
        chk("cap_c5_rdy", 64'(bus.req_ready_o), 64'b0001);
        do_reset();

        // Same-cycle issue and completion for requester 1 leaves count at 1.
        bus.req_valid_i     = 4'b0010;
        bus.mem_req_ready_i = 1'b1;
        #1;
        chk("same_c1_rdy", 64'(bus.req_ready_o), 64'b0010); tick();
        set_resp(4'b0100, 32'h7);
        bus.resp_ready_i = 4'b0010;
        #1;
        chk("same_c2_rdy", 64'(bus.req_ready_o), 64'b0010);
        chk("same_c2_resp_rdy", 64'(bus.mem_resp_ready_o), 64'd1);
        tick();
        bus.mem_resp_valid_i = 1'b0;
        #1;
        chk("same_c3_rdy", 64'(bus.req_ready_o), 64'b0010); tick(); #1;
        chk("same_c4_vld", 64'(bus.mem_req_valid_o), 64'(!LIM));
        chk("same_c4_rdy", 64'(bus.req_ready_o), LIM ? 64'b0000 : 64'b0010);
        do_reset();

        // Reset while locked on requester 2 with requester 0 at its cap.
        bus.req_valid_i     = 4'b0001;
        bus.mem_req_ready_i = 1'b1;
        tick();
        tick();
        bus.req_valid_i     = 4'b0101;
        bus.mem_req_ready_i = 1'b0;
        #1;
        chk_grant("mid_lock", 2, 4'b0000);
        tick();
        rst = 1'b1;
        bus.req_valid_i     = 4'b1101;
        bus.mem_req_ready_i = 1'b1;
        bus.resp_ready_i    = 4'b1111;
        set_resp(4'b0001, 32'h9);
        #1;
        chk("mid_rst_vld", 64'(bus.mem_req_valid_o), 64'd0);
        chk("mid_rst_rdy", 64'(bus.req_ready_o), 64'd0);
        chk("mid_rst_resp_vld", 64'(bus.resp_valid_o), 64'd0);
        chk("mid_rst_resp_rdy", 64'(bus.mem_resp_ready_o), 64'd0);
        tick();
        rst = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        #1;
        chk_grant("post_rst", 0, 4'b0000);
        tick();
        bus.mem_req_ready_i = 1'b1;
        #1;
        chk_grant("post_rst_hs", 0, 4'b0001);
        tick();
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
